ex_stage: RTL

- Execute stage of the 5-stage pipelined processor.
- Sits between the ID/EX and EX/MEM pipeline registers.
- Consumes the decoded instruction, operands and immediate from ID; computes the ALU result, effective address or branch target.
- Resolves branches and drives the taken-branch redirect to IF.
- Implements MUL as an iterative shift-add unit that stalls upstream while busy.

---
 rtl/proc_defs.sv | 55 +++++
 rtl/iter_mul.sv | 61 ++++++
 rtl/ex_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/proc_defs.sv
// Shared processor definitions used by all pipeline stages.
// Contents: datapath width, opcode and instruction-type encodings,
// EX-stage FSM states, the EX/MEM payload struct and a branch-redirect helper.
package proc_defs;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;
  localparam int unsigned TY_W = 3;

  // Opcodes (instruction bits [31:26])
  localparam logic [OP_W-1:0] ADD   = 6'b000000;
  localparam logic [OP_W-1:0] SUB   = 6'b000001;
  localparam logic [OP_W-1:0] AND   = 6'b000010;
  localparam logic [OP_W-1:0] OR    = 6'b000011;
  localparam logic [OP_W-1:0] SLT   = 6'b000100;
  localparam logic [OP_W-1:0] MUL   = 6'b000101;
  localparam logic [OP_W-1:0] LW    = 6'b001000;
  localparam logic [OP_W-1:0] SW    = 6'b001001;
  localparam logic [OP_W-1:0] ADDI  = 6'b001010;
  localparam logic [OP_W-1:0] SUBI  = 6'b001011;
  localparam logic [OP_W-1:0] SLTI  = 6'b001100;
  localparam logic [OP_W-1:0] BNEQZ = 6'b001101;
  localparam logic [OP_W-1:0] BEQZ  = 6'b001110;
  localparam logic [OP_W-1:0] HLT   = 6'b111111;

  // Instruction type codes
  localparam logic [TY_W-1:0] RR_ALU = 3'd0;
  localparam logic [TY_W-1:0] RM_ALU = 3'd1;
  localparam logic [TY_W-1:0] LOAD   = 3'd2;
  localparam logic [TY_W-1:0] STORE  = 3'd3;
  localparam logic [TY_W-1:0] BRANCH = 3'd4;
  localparam logic [TY_W-1:0] HALT   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } ex_state_t;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ir;
    logic [TY_W-1:0] itype;
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] b;
    logic            cond;
  } ex_mem_t;

  // A branch redirects IF when BEQZ sees zero or BNEQZ sees non-zero
  function automatic logic is_redirect(input logic [OP_W-1:0] op, input logic cond);
    return ((op == BEQZ) && cond) || ((op == BNEQZ) && !cond);
  endfunction

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// Ports: clk1/reset (async active-high); start loads a (multiplicand) and
// b (multiplier); busy is high while iterating; last_c flags the final
// iteration edge; done is high once the product is complete (until next start);
// product holds the low XLEN bits of a*b.
module iter_mul
  import proc_defs::*;
#(
  parameter int unsigned MUL_BITS = 32
) (
  input  logic            clk1,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            last_c,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CW = $clog2(MUL_BITS + 1);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;

  // Iteration about to bring cnt up to MUL_BITS
  assign last_c  = busy && (cnt == CW'(MUL_BITS - 1));
  assign product = acc;

  // Shift-add datapath and iteration counter
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_c) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage pipeline: ALU, effective address, branch
// target/resolution, and an iterative MUL that stalls ID while running.
// Ports: clk1/reset (async active-high); id_ex_* instruction from ID;
// ex_ready accepts id_ex; mem_ready backpressure from MEM; ex_mem_* EX/MEM
// register; branch_taken redirect to IF; sticky halted and illegal flags.
module ex_stage
  import proc_defs::*;
#(
  parameter int unsigned MUL_BITS = 32
) (
  input  logic            clk1,
  input  logic            reset,
  input  logic            id_ex_valid,
  input  logic [XLEN-1:0] id_ex_ir,
  input  logic [XLEN-1:0] id_ex_npc,
  input  logic [XLEN-1:0] id_ex_a,
  input  logic [XLEN-1:0] id_ex_b,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [TY_W-1:0] id_ex_type,
  output logic            ex_ready,
  input  logic            mem_ready,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_ir,
  output logic [TY_W-1:0] ex_mem_type,
  output logic [XLEN-1:0] ex_mem_aluout,
  output logic [XLEN-1:0] ex_mem_b,
  output logic            ex_mem_cond,
  output logic            branch_taken,
  output logic            halted,
  output logic            illegal
);

  ex_state_t       state;
  ex_mem_t         em;
  logic [XLEN-1:0] mul_ir;
  logic [XLEN-1:0] mul_b;
  logic [TY_W-1:0] mul_type;

  logic [OP_W-1:0] op;
  logic            adv;
  logic            accept;
  logic            take;
  logic [XLEN-1:0] res;
  logic            cond_c;
  logic            legal_c;
  logic            is_mul_c;
  logic            is_hlt_c;

  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic            mul_last_c;
  logic [XLEN-1:0] mul_prod;

  assign op       = id_ex_ir[XLEN-1 -: OP_W];
  assign adv      = !em.valid || mem_ready;
  assign ex_ready = (state == S_IDLE) && adv && !halted;
  assign accept   = id_ex_valid && ex_ready;
  // Wrong-path instruction behind a taken branch is dropped entirely
  assign take      = accept && !branch_taken;
  assign mul_start = take && is_mul_c;

  assign ex_mem_valid  = em.valid;
  assign ex_mem_ir     = em.ir;
  assign ex_mem_type   = em.itype;
  assign ex_mem_aluout = em.aluout;
  assign ex_mem_b      = em.b;
  assign ex_mem_cond   = em.cond;

  // Single-cycle result and opcode decode
  always_comb begin
    res      = '0;
    cond_c   = 1'b0;
    legal_c  = 1'b1;
    is_mul_c = 1'b0;
    is_hlt_c = 1'b0;
    case (op)
      ADD:   res = id_ex_a + id_ex_b;
      SUB:   res = id_ex_a - id_ex_b;
      AND:   res = id_ex_a & id_ex_b;
      OR:    res = id_ex_a | id_ex_b;
      SLT:   res = XLEN'($signed(id_ex_a) < $signed(id_ex_b));
      ADDI:  res = id_ex_a + id_ex_imm;
      SUBI:  res = id_ex_a - id_ex_imm;
      SLTI:  res = XLEN'($signed(id_ex_a) < $signed(id_ex_imm));
      LW,
      SW:    res = id_ex_a + id_ex_imm;
      BEQZ,
      BNEQZ: begin
        res    = id_ex_npc + id_ex_imm;
        cond_c = (id_ex_a == '0);
      end
      MUL:   is_mul_c = 1'b1;
      HLT:   is_hlt_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  // MUL control FSM, EX/MEM register and sticky status
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      em           <= '0;
      branch_taken <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      mul_ir       <= '0;
      mul_b        <= '0;
      mul_type     <= '0;
    end else begin
      case (state)
        S_IDLE:  if (mul_start) state <= S_RUN;
        S_RUN:   if (mul_busy && mul_last_c) state <= S_DONE;
        S_DONE:  if (adv && mul_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        if ((state == S_DONE) && mul_done) begin
          em <= '{valid: 1'b1, ir: mul_ir, itype: mul_type,
                  aluout: mul_prod, b: mul_b, cond: 1'b0};
          branch_taken <= 1'b0;
        end else if (take && legal_c && !is_mul_c) begin
          em <= '{valid: 1'b1, ir: id_ex_ir, itype: id_ex_type,
                  aluout: res, b: id_ex_b, cond: cond_c};
          branch_taken <= is_redirect(op, cond_c);
        end else begin
          em.valid     <= 1'b0;
          branch_taken <= 1'b0;
        end
      end

      if (take && is_hlt_c) halted  <= 1'b1;
      if (take && !legal_c) illegal <= 1'b1;

      // Keep the MUL's identity for its eventual EX/MEM write
      if (mul_start) begin
        mul_ir   <= id_ex_ir;
        mul_b    <= id_ex_b;
        mul_type <= id_ex_type;
      end
    end
  end

  iter_mul #(
    .MUL_BITS(MUL_BITS)
  ) u_mul (
    .clk1    (clk1),
    .reset   (reset),
    .start   (mul_start),
    .a       (id_ex_a),
    .b       (id_ex_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .last_c  (mul_last_c),
    .product (mul_prod)
  );

endmodule
